mac_align_acc: RTL

Align-and-accumulate stage directly downstream of the exponent/mantissa multiply stages of the quantized MAC. It accepts a stream of products, each carrying a signed mantissa and a 4-bit exponent, shifts each mantissa left by its exponent into a wide two's-complement term, and sums a programmed number of terms with saturation. The final dot-product sum is presented on a valid/ready output.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_align.sv | 54 +++++
 rtl/mac_align_acc.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg
// Shared definitions for the align-and-accumulate stage of the quantized MAC:
//   - state_t   : FSM states (IDLE, ACC, DRAIN, DONE)
//   - EXP_W     : width of the product exponent / left-shift amount
//   - sat_max / sat_min : saturation limits of an ACC_W-bit signed accumulator,
//                         returned in the low ACC_W bits of a 64-bit value
package mac_pkg;

    localparam int EXP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest positive value: 2^(acc_w-1) - 1
    function automatic logic [63:0] sat_max(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    // Most negative value: -2^(acc_w-1). Only the low acc_w bits are meaningful.
    function automatic logic [63:0] sat_min(input int acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/mac_align.sv
// mac_align
// Registered align stage: sign-extends the product mantissa to ACC_W bits and
// shifts it left by the product exponent. The valid bit travels alongside the
// term so the accumulator knows which cycles carry a product.
// The shift is exact as long as MANT_W + 15 <= ACC_W.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_i     : a product is being accepted this cycle
//   exp_i       : unsigned left-shift amount (0..15)
//   mant_i      : signed product mantissa
//   valid_o     : registered valid for term_o
//   term_o      : registered aligned two's-complement term
module mac_align
    import mac_pkg::*;
#(
    parameter int MANT_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [MANT_W-1:0] mant_i,
    output logic              valid_o,
    output logic [ACC_W-1:0]  term_o
);

    logic [ACC_W-1:0] mant_ext;
    logic [ACC_W-1:0] term_d;
    logic [ACC_W-1:0] term_q;
    logic             valid_q;

    assign mant_ext = {{(ACC_W-MANT_W){mant_i[MANT_W-1]}}, mant_i};
    assign term_d   = mant_ext << exp_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            term_q  <= '0;
        end else begin
            valid_q <= valid_i;
            // Only capture on a real product so the term register stays quiet
            // during bubbles.
            if (valid_i) begin
                term_q <= term_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign term_o  = term_q;

endmodule

// File: rtl/mac_align_acc.sv
// mac_align_acc
// Align-and-accumulate stage of the quantized MAC. Accepts len products
// (mantissa, exponent), aligns each into a wide term (mac_align), and sums the
// terms with saturation. The sum is offered on a valid/ready output.
//
// Handshake: a product transfers on a rising edge where in_valid && in_ready;
// the sum transfers on a rising edge where out_valid && out_ready. in_ready and
// out_valid depend only on registered state, never on the same-cycle inputs.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, len            : begin a job of len products (honoured only in IDLE)
//   in_valid/in_ready     : product handshake
//   in_exp, in_mant       : product exponent (shift amount) and signed mantissa
//   out_valid/out_ready   : sum handshake
//   out_sum, out_ovf      : registered sum and sticky saturation flag
//   busy                  : FSM not in IDLE
//   dbg_state             : current FSM state encoding, for observation
module mac_align_acc
    import mac_pkg::*;
#(
    parameter int MANT_W = 8,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [63:0]      MAX64   = sat_max(ACC_W);
    localparam logic [63:0]      MIN64   = sat_min(ACC_W);
    localparam logic [ACC_W-1:0] ACC_MAX = MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] ACC_MIN = MIN64[ACC_W-1:0];

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              term_valid;
    logic [ACC_W-1:0]  term;
    logic [ACC_W:0]    sum_wide;
    logic              sum_ovf;
    logic [ACC_W-1:0]  sum_sat;

    assign accept = in_valid && (state_q == ACC);

    mac_align #(
        .MANT_W (MANT_W),
        .ACC_W  (ACC_W)
    ) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .exp_i   (in_exp),
        .mant_i  (in_mant),
        .valid_o (term_valid),
        .term_o  (term)
    );

    // One extra bit of headroom: the two top bits disagree exactly when the
    // ACC_W-bit signed result has overflowed, and the top bit gives the
    // direction (0 = positive overflow, 1 = negative overflow).
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_sat  = !sum_ovf         ? sum_wide[ACC_W-1:0] :
                      sum_wide[ACC_W]  ? ACC_MIN : ACC_MAX;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        // A term arrives one edge after its accept; the last one lands during
        // DRAIN, which is why DRAIN exists.
        if (term_valid) begin
            acc_d = sum_sat;
            ovf_d = ovf_q | sum_ovf;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = len;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule
